// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared types and defaults for the add/sub round-robin arbiter slice.
// Holds the FSM state encoding and the pointer-advance helper.
package addsub_rr_arbiter_pkg;

  localparam int unsigned ARB_W    = 32;
  localparam int unsigned ARB_NREQ = 4;
  localparam int unsigned ARB_IDW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Increment with wrap at n; used to move the round-robin pointer past the last winner.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request/response bus between the ALU front-end ports and the add/sub arbiter.
// master = requesters and result consumer, slave = arbiter.
interface addsub_rr_arbiter_if
  import addsub_rr_arbiter_pkg::*;
#(
  parameter int unsigned W    = ARB_W,
  parameter int unsigned NREQ = ARB_NREQ,
  parameter int unsigned IDW  = ARB_IDW
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_m;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_s;
  logic              rsp_cout;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/addsub_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
// Produces a one-hot grant, the winning index and an any-request flag.
module addsub_rr_arbiter_rr_pick
  import addsub_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ,
  parameter int unsigned IDW  = ARB_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Pass one covers [ptr, NREQ-1]; pass two wraps around and only fires if pass one found nothing.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (32'(ptr) <= i)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one external n_bit_adder between NREQ requesters: grant, execute, return result with id.
// Define ARB_OVF_EN to build the signed-overflow capture; otherwise rsp_ovf is tied low.
module addsub_rr_arbiter
  import addsub_rr_arbiter_pkg::*;
#(
  parameter int unsigned W    = ARB_W,
  parameter int unsigned NREQ = ARB_NREQ,
  parameter int unsigned IDW  = ARB_IDW
) (
  input  logic                      clk,
  input  logic                      rst,
  addsub_rr_arbiter_if.slave        bus,
  output logic [W-1:0]              add_a,
  output logic [W-1:0]              add_b,
  output logic                      add_m,
  input  logic [W-1:0]              add_s,
  input  logic                      add_cout,
  output logic                      busy
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            op_m_q, op_m_d;
  logic [W-1:0]    rsp_s_q, rsp_s_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_valid_q, busy_q;

  logic [NREQ-1:0] gnt_c, req_ready_c;
  logic [IDW-1:0]  win_c;
  logic            any_c;
  logic [W-1:0]    sel_a_c, sel_b_c;
  logic            sel_m_c;

  addsub_rr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt_c),
    .idx (win_c),
    .any (any_c)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    sel_m_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        sel_a_c = bus.req_a[i*W +: W];
        sel_b_c = bus.req_b[i*W +: W];
        sel_m_c = bus.req_m[i];
      end
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_m_d      = op_m_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    req_ready_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          req_ready_c = gnt_c;
          op_a_d      = sel_a_c;
          op_b_d      = sel_b_c;
          op_m_d      = sel_m_c;
          id_d        = win_c;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_s_d    = add_s;
        rsp_cout_d = add_cout;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = IDW'(wrap_inc(32'(id_q), NREQ));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_m_q      <= 1'b0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_m_q      <= op_m_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

`ifdef ARB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: effective operand signs agree but the result sign differs from A.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_EXEC) begin
      ovf_d = (op_a_q[W-1] == (op_b_q[W-1] ^ op_m_q)) && (add_s[W-1] != op_a_q[W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

  // Grant strobe is combinational so the winner transfers in the same IDLE cycle.
  assign bus.req_ready = rst ? '0 : req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign add_a         = op_a_q;
  assign add_b         = op_b_q;
  assign add_m         = op_m_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter with an external adder model and a
// behavioural round-robin reference; honours ARB_OVF_EN for the rsp_ovf expectation.
module tb_addsub_rr_arbiter;
  import addsub_rr_arbiter_pkg::*;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_m, add_cout, busy;

  addsub_rr_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

  addsub_rr_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_m    (add_m),
    .add_s    (add_s),
    .add_cout (add_cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // The shared adder that sits outside the arbiter.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b ^ {W{add_m}}} + (W+1)'(add_m);

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   s;
    logic           cout;
    logic           ovf;
    int             cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           mptr = 0;
  bit           mbusy = 1'b0;
  bit           rsp_seen = 1'b0;
  logic [W-1:0] pa[NREQ];
  logic [W-1:0] pb[NREQ];
  logic         pm[NREQ];
  logic         pv[NREQ];
  logic         taken[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result from the arithmetic meaning of add / subtract.
  function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic m, input int id, input int c);
    exp_t         e;
    logic [W:0]   sum;
    logic         ovf;
    if (!m) begin
      sum    = {1'b0, a} + {1'b0, b};
      e.s    = sum[W-1:0];
      e.cout = sum[W];
      ovf    = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    end else begin
      e.s    = a - b;
      e.cout = (a >= b);
      ovf    = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    end
`ifdef ARB_OVF_EN
    e.ovf = ovf;
`else
    e.ovf = 1'b0;
`endif
    e.id  = IDW'(id);
    e.cyc = c;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]     = pv[i];
      bus.req_a[i*W +: W]  = pa[i];
      bus.req_b[i*W +: W]  = pb[i];
      bus.req_m[i]         = pm[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (taken[i]) begin
        pv[i]    = 1'b0;
        taken[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    pa[i] = a;
    pb[i] = b;
    pm[i] = m;
    pv[i] = 1'b1;
  endtask

  function automatic bit any_pv();
    for (int i = 0; i < NREQ; i++) if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done();
    int n = 0;
    while ((any_pv() || exp_q.size() != 0 || mbusy) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n >= 300), 64'd0);
  endtask

  // Monitor / scoreboard: predicts grants, pushes expectations, checks responses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
        exp_q.delete();
        mptr     = 0;
        mbusy    = 1'b0;
        rsp_seen = 1'b0;
      end else begin
        bit   nbusy;
        int   w;
        exp_t e;
        nbusy = mbusy;
        chk("busy", 64'(busy), 64'(mbusy));
        if (!mbusy && bus.req_valid != '0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (mptr + k) % NREQ;
            if (w < 0 && bus.req_valid[j]) w = j;
          end
          chk("grant", 64'(bus.req_ready), 64'(1) << w);
          e = model_op(pa[w], pb[w], pm[w], w, cyc);
          exp_q.push_back(e);
          taken[w] = 1'b1;
          acc_cnt++;
          nbusy = 1'b1;
        end else begin
          chk("no_grant", 64'(bus.req_ready), 64'd0);
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected act=1 exp=0 (cyc %0d)", cyc);
          end else begin
            if (!rsp_seen) chk("latency", 64'(cyc - exp_q[0].cyc), 64'd2);
            rsp_seen = 1'b1;
            chk("rsp_id",   64'(bus.rsp_id),   64'(exp_q[0].id));
            chk("rsp_s",    64'(bus.rsp_s),    64'(exp_q[0].s));
            chk("rsp_cout", 64'(bus.rsp_cout), 64'(exp_q[0].cout));
            chk("rsp_ovf",  64'(bus.rsp_ovf),  64'(exp_q[0].ovf));
            if (bus.rsp_ready) begin
              mptr = (int'(exp_q[0].id) + 1) % NREQ;
              void'(exp_q.pop_front());
              rsp_seen = 1'b0;
              nbusy    = 1'b0;
            end
          end
        end else if (exp_q.size() != 0 && (cyc - exp_q[0].cyc) >= 2) begin
          checks++;
          errors++;
          $display("FAIL rsp_late act=0 exp=1 (cyc %0d)", cyc);
        end
        mbusy = nbusy;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int old, n;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pm[i] = 1'b0; pv[i] = 1'b0; taken[i] = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_add_a",     64'(add_a),         64'd0);
    chk("rst_add_b",     64'(add_b),         64'd0);
    chk("rst_add_m",     64'(add_m),         64'd0);
    chk("rst_rsp_s",     64'(bus.rsp_s),     64'd0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    chk("rst_rsp_cout",  64'(bus.rsp_cout),  64'd0);
    chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'd0);

    set_op(0, 32'd12, 32'd2348, 1'b0);
    drive();
    wait_done();

    set_op(2, 32'd1672, 32'd967, 1'b1);
    drive();
    wait_done();

    // All four held valid: expect rotating grants.
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    drive();
    old = acc_cnt;
    n = 0;
    while (acc_cnt - old < 5 && n < 100) begin
      tick();
      if (acc_cnt - old < 4)
        for (int i = 0; i < NREQ; i++)
          if (!pv[i]) set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      drive();
      n++;
    end
    chk("rr_burst_timeout", 64'(n >= 100), 64'd0);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    drive();
    wait_done();

    // Back-pressure in RESP with a new request waiting.
    set_op(0, rnd_op(), rnd_op(), 1'b0);
    bus.rsp_ready = 1'b0;
    drive();
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("resp_wait_timeout", 64'(n >= 20), 64'd0);
    set_op(1, rnd_op(), rnd_op(), 1'b1);
    drive();
    repeat (5) tick();
    bus.rsp_ready = 1'b1;
    drive();
    wait_done();

    set_op(3, 32'h7FFF_FFFF, 32'd1, 1'b0);
    drive();
    wait_done();

    // Reset while the operation is in EXEC.
    set_op(3, rnd_op(), rnd_op(), 1'b0);
    drive();
    old = acc_cnt;
    n = 0;
    while (acc_cnt == old && n < 20) begin
      tick();
      n++;
    end
    chk("exec_wait_timeout", 64'(n >= 20), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(1, rnd_op(), rnd_op(), 1'b0);
    set_op(2, rnd_op(), rnd_op(), 1'b1);
    drive();
    wait_done();

    // Randomized traffic with drops and back-pressure.
    for (int c = 0; c < 2500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i]) begin
          if ($urandom_range(0, 3) == 0) set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      drive();
    end
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    bus.rsp_ready = 1'b1;
    drive();
    wait_done();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
